// File: rtl/mini68k_exc_sequencer_if.sv
// Mini68k exception sequencer memory bus: 16-bit word transfers
// with a request / acknowledge / error handshake.
interface mini68k_exc_sequencer_if #(
    parameter int ADDR_W = 24
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [15:0]       bus_wdata;
    logic [15:0]       bus_rdata;
    logic              bus_ack;
    logic              bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/mini68k_exc_sequencer.sv
// Mini68k exception sequencer: stacks PC/SR, fetches the vector, loads PC/SR/SSP.
// MINI68K_EXC_TIMEOUT_EN adds a per-transfer timeout that halts like a bus error.
module mini68k_exc_sequencer #(
    parameter int ADDR_W = 24
`ifdef MINI68K_EXC_TIMEOUT_EN
    ,
    parameter int BUS_TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exception_req,
    input  logic [7:0]  vector_num,
    input  logic        enter_supervisor,
    output logic        exception_ack,
    input  logic [31:0] cur_pc,
    input  logic [15:0] cur_sr,
    input  logic [31:0] cur_ssp,
    mini68k_exc_sequencer_if.master bus,
    output logic        pc_load,
    output logic [31:0] pc_new,
    output logic        sr_load,
    output logic [15:0] sr_new,
    output logic        ssp_load,
    output logic [31:0] ssp_new,
    output logic        busy,
    output logic        halted
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] SNAP     = 4'd1;
    localparam logic [3:0] PUSH_PCL = 4'd2;
    localparam logic [3:0] PUSH_PCH = 4'd3;
    localparam logic [3:0] PUSH_SR  = 4'd4;
    localparam logic [3:0] FETCH_VH = 4'd5;
    localparam logic [3:0] FETCH_VL = 4'd6;
    localparam logic [3:0] LOAD     = 4'd7;
    localparam logic [3:0] ACK      = 4'd8;
    localparam logic [3:0] HALT     = 4'd9;

    logic [3:0]  state;
    logic [3:0]  state_n;
    logic [7:0]  vec_q;
    logic [31:0] pc_q;
    logic [15:0] sr_q;
    logic [31:0] ssp_q;
    logic [15:0] sr_calc;
    logic [31:0] va;
    logic        fault;
    logic        done;

    assign va = {22'd0, vec_q, 2'b00};

`ifdef MINI68K_EXC_TIMEOUT_EN
    logic [15:0] tcnt;

    // Counts stalled cycles of the current transfer; cleared once it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (!bus.bus_req || bus.bus_ack) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign fault = bus.bus_req &&
                   (bus.bus_err ||
                    (!bus.bus_ack && tcnt >= 16'(BUS_TIMEOUT - 1)));
`else
    assign fault = bus.bus_req && bus.bus_err;
`endif

    assign done = bus.bus_req && bus.bus_ack && !fault;

    always_comb begin
        sr_calc     = cur_sr;
        sr_calc[15] = 1'b0;
        sr_calc[13] = cur_sr[13] | enter_supervisor;
        if (vector_num >= 8'd25 && vector_num <= 8'd31) begin
            sr_calc[10:8] = 3'(vector_num - 8'd24);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (exception_req) state_n = SNAP;
            SNAP:     state_n = PUSH_PCL;
            PUSH_PCL, PUSH_PCH, PUSH_SR, FETCH_VH, FETCH_VL: begin
                if (fault) begin
                    state_n = HALT;
                end else if (bus.bus_ack) begin
                    state_n = state + 4'd1;
                end
            end
            LOAD:     state_n = ACK;
            ACK:      state_n = IDLE;
            HALT:     state_n = HALT;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        case (state)
            PUSH_PCL: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = ADDR_W'(ssp_q - 32'd2);
                bus.bus_wdata = pc_q[15:0];
            end
            PUSH_PCH: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = ADDR_W'(ssp_q - 32'd4);
                bus.bus_wdata = pc_q[31:16];
            end
            PUSH_SR: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = ADDR_W'(ssp_q - 32'd6);
                bus.bus_wdata = sr_q;
            end
            FETCH_VH: begin
                bus.bus_req  = 1'b1;
                bus.bus_addr = ADDR_W'(va);
            end
            FETCH_VL: begin
                bus.bus_req  = 1'b1;
                bus.bus_addr = ADDR_W'(va + 32'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec_q   <= '0;
            pc_q    <= '0;
            sr_q    <= '0;
            ssp_q   <= '0;
            sr_new  <= '0;
            ssp_new <= '0;
            pc_new  <= '0;
        end else begin
            state <= state_n;
            if (state == SNAP) begin
                vec_q   <= vector_num;
                pc_q    <= cur_pc;
                sr_q    <= cur_sr;
                ssp_q   <= cur_ssp;
                sr_new  <= sr_calc;
                ssp_new <= cur_ssp - 32'd6;
            end
            if (state == FETCH_VH && done) pc_new[31:16] <= bus.bus_rdata;
            if (state == FETCH_VL && done) pc_new[15:0] <= bus.bus_rdata;
        end
    end

    assign pc_load       = (state == LOAD);
    assign sr_load       = (state == LOAD);
    assign ssp_load      = (state == LOAD);
    assign exception_ack = (state == ACK);
    assign halted        = (state == HALT);
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mini68k_exc_sequencer.sv
// Randomized scoreboard bench for mini68k_exc_sequencer: a memory responder
// with configurable wait states feeds a monitor that checks against queued expectations.
module tb_mini68k_exc_sequencer;
    localparam int AW = 24;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] data;
    } xfer_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] sr;
        logic [31:0] ssp;
    } load_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exception_req = 1'b0;
    logic [7:0]  vector_num = '0;
    logic        enter_supervisor = 1'b0;
    logic [31:0] cur_pc = '0;
    logic [15:0] cur_sr = '0;
    logic [31:0] cur_ssp = '0;
    logic        exception_ack;
    logic        pc_load, sr_load, ssp_load, busy, halted;
    logic [31:0] pc_new, ssp_new;
    logic [15:0] sr_new;

    mini68k_exc_sequencer_if #(.ADDR_W(AW)) bus();

    mini68k_exc_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .exception_req(exception_req),
        .vector_num(vector_num),
        .enter_supervisor(enter_supervisor),
        .exception_ack(exception_ack),
        .cur_pc(cur_pc),
        .cur_sr(cur_sr),
        .cur_ssp(cur_ssp),
        .bus(bus),
        .pc_load(pc_load),
        .pc_new(pc_new),
        .sr_load(sr_load),
        .sr_new(sr_new),
        .ssp_load(ssp_load),
        .ssp_new(ssp_new),
        .busy(busy),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int waits = 0;
    int err_at = -1;
    int xidx = 0;
    int wcnt = 0;
    bit noack = 1'b0;

    logic [15:0] mem [int];
    xfer_t exp_x[$];
    load_t exp_l[$];
    int    exp_ack[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] rd(input logic [31:0] a);
        int k = int'(a[23:0]);
        return mem.exists(k) ? mem[k] : 16'h0000;
    endfunction

    // Memory responder: applies `waits` stall cycles per transfer, then ack or err.
    initial begin
        bus.bus_ack = 1'b0;
        bus.bus_err = 1'b0;
        bus.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.bus_ack = 1'b0;
                bus.bus_err = 1'b0;
                bus.bus_rdata = '0;
                wcnt = 0;
            end else begin
                if (bus.bus_ack) begin
                    xidx++;
                    wcnt = 0;
                end
                bus.bus_ack = 1'b0;
                bus.bus_err = 1'b0;
                bus.bus_rdata = '0;
                if (bus.bus_req && !noack) begin
                    if (wcnt < waits) begin
                        wcnt++;
                    end else if (xidx == err_at) begin
                        bus.bus_err = 1'b1;
                    end else begin
                        bus.bus_ack = 1'b1;
                        if (bus.bus_we) mem[int'(bus.bus_addr)] = bus.bus_wdata;
                        else bus.bus_rdata = rd(32'(bus.bus_addr));
                    end
                end
            end
        end
    end

    // Monitor: compares every completed transfer, load pulse and ack against the queues.
    always @(negedge clk) begin
        xfer_t x;
        load_t l;
        int a;
        if (rst_n) begin
            if (bus.bus_req && bus.bus_ack && !bus.bus_err) begin
                if (exp_x.size() == 0) begin
                    chk("xfer_unexpected", 32'(bus.bus_addr), 32'hFFFF_FFFF);
                end else begin
                    x = exp_x.pop_front();
                    chk("xfer_we", 32'(bus.bus_we), 32'(x.we));
                    chk("xfer_addr", 32'(bus.bus_addr), 32'(x.addr));
                    if (x.we) chk("xfer_wdata", 32'(bus.bus_wdata), 32'(x.data));
                end
            end
            if (pc_load) begin
                if (exp_l.size() == 0) begin
                    chk("load_unexpected", 32'(pc_load), 32'd0);
                end else begin
                    l = exp_l.pop_front();
                    chk("load_pulses", {30'd0, sr_load, ssp_load}, 32'd3);
                    chk("pc_new", pc_new, l.pc);
                    chk("sr_new", 32'(sr_new), 32'(l.sr));
                    chk("ssp_new", ssp_new, l.ssp);
                end
            end
            if (exception_ack) begin
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", 32'(exception_ack), 32'd0);
                end else begin
                    a = exp_ack.pop_front();
                    chk("ack_cycle", 32'(cyc - t0), 32'(a));
                end
            end
        end
    end

    // Reference model: expected frame, vector fetch and new register values.
    task automatic issue(input logic [7:0] v, input bit es, input logic [31:0] pc,
                         input logic [15:0] sr, input logic [31:0] ssp,
                         input int w, input int ea);
        logic [31:0] va, a2, a4, a6;
        logic [15:0] s;
        xfer_t x[5];
        load_t l;
        int n;
        va = {22'd0, v, 2'b00};
        a2 = ssp - 32'd2;
        a4 = ssp - 32'd4;
        a6 = ssp - 32'd6;
        x[0] = {1'b1, a2[23:0], pc[15:0]};
        x[1] = {1'b1, a4[23:0], pc[31:16]};
        x[2] = {1'b1, a6[23:0], sr};
        x[3] = {1'b0, va[23:0], 16'h0};
        a2 = va + 32'd2;
        x[4] = {1'b0, a2[23:0], 16'h0};
        n = (ea < 0) ? 5 : ea;
        for (int i = 0; i < n; i++) exp_x.push_back(x[i]);
        if (ea < 0) begin
            s = sr & 16'h7FFF;
            if (es) s = s | 16'h2000;
            if (v >= 25 && v <= 31) s = (s & 16'hF8FF) | 16'((v - 24) << 8);
            l.pc = {rd(va), rd(va + 32'd2)};
            l.sr = s;
            l.ssp = a6;
            exp_l.push_back(l);
            exp_ack.push_back(8 + 5 * w);
        end
        waits = w;
        err_at = ea;
        xidx = 0;
        wcnt = 0;
        @(posedge clk);
        #1;
        vector_num = v;
        enter_supervisor = es;
        cur_pc = pc;
        cur_sr = sr;
        cur_ssp = ssp;
        exception_req = 1'b1;
        t0 = cyc;
    endtask

    task automatic finish_exc(input bit expect_ack);
        bit ack_seen = 1'b0;
        bit halt_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vector_num = 8'($urandom);
        enter_supervisor = 1'($urandom);
        cur_pc = $urandom;
        cur_sr = 16'($urandom);
        cur_ssp = $urandom;
        for (int i = 0; i < 400 && !ack_seen && !halt_seen; i++) begin
            @(negedge clk);
            ack_seen = exception_ack;
            halt_seen = halted;
        end
        if (expect_ack) begin
            chk("ack_seen", 32'(ack_seen), 32'd1);
            @(posedge clk);
            #1;
            exception_req = 1'b0;
            repeat (2) @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
        end else begin
            chk("halt_seen", 32'(halt_seen), 32'd1);
        end
        chk("sb_drained", 32'(exp_x.size() + exp_l.size() + exp_ack.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {24'd0, busy, halted, exception_ack, pc_load,
                            sr_load, ssp_load, bus.bus_req, bus.bus_we}, 32'd0);
        chk({tag, "_addr"}, 32'(bus.bus_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.bus_wdata), 32'd0);
        chk({tag, "_regs"}, pc_new | ssp_new | 32'(sr_new), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exception_req = 1'b0;
        exp_x.delete();
        exp_l.delete();
        exp_ack.delete();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] ssp;
        logic [7:0] v;
        bit found;
        for (int a = 0; a < 1024; a += 2) mem[a] = 16'($urandom);
        mem[16'h0010] = 16'h0000;
        mem[16'h0012] = 16'h0400;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("por");
        rst_n = 1'b1;

        issue(8'd4, 1'b1, 32'h0000_1234, 16'h0700, 32'h0000_1000, 0, -1);
        finish_exc(1'b1);

        issue(8'd29, 1'b0, $urandom, 16'h2000, 32'h0002_0000, 2, -1);
        finish_exc(1'b1);

        issue(8'd4, 1'b0, 32'h0000_0002, 16'h0000, 32'h0000_0002, 0, -1);
        finish_exc(1'b1);

        issue(8'd4, 1'b1, 32'hCAFE_0010, 16'h0300, 32'h0000_3000, 1, 1);
        finish_exc(1'b0);
        repeat (20) @(negedge clk);
        chk("halt_hold", {30'd0, halted, busy}, 32'd3);
        chk("halt_no_req", 32'(bus.bus_req), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        issue(8'd5, 1'b0, 32'h1111_2222, 16'h0001, 32'h0000_8000, 2, -1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.bus_req && !bus.bus_we;
        end
        chk("reach_fetch", 32'(found), 32'd1);
        #2;
        do_reset();
        issue(8'd6, 1'b1, 32'h3333_4444, 16'hA71F, 32'h0000_9000, 1, -1);
        finish_exc(1'b1);

        for (int r = 0; r < 12; r++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 1) == 1) v = 8'($urandom_range(23, 33));
            ssp = $urandom & 32'hFFFF_FFFE;
            if (ssp[23:12] == 12'd0) ssp[12] = 1'b1;
            issue(v, 1'($urandom), $urandom, 16'($urandom), ssp, $urandom_range(0, 3), -1);
            finish_exc(1'b1);
        end

        noack = 1'b1;
        issue(8'd4, 1'b0, 32'h0, 16'h0, 32'h0000_1000, 0, 0);
        repeat (300) @(negedge clk);
`ifdef MINI68K_EXC_TIMEOUT_EN
        chk("timeout_halt", 32'(halted), 32'd1);
`else
        chk("stall_busy", {30'd0, busy, halted}, 32'd2);
`endif
        @(posedge clk);
        #1;
        noack = 1'b0;
        do_reset();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
